m_dm_sbuf: RTL and testbench

//  Store buffer in the M stage, directly upstream of m_dm. Queues M-stage stores in a FIFO and

---
 rtl/m_dm_sbuf.sv | 101 ++++++++++
 tb/tb_m_dm_sbuf.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/m_dm_sbuf.sv
// M-stage store buffer: queues stores and drains them to the single m_dm port.
// Loads win the port unless they hit a pending store word, in which case they stall.
module m_dm_sbuf #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH+1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          stWrite,
    input  logic [31:0]   stAddr,
    input  logic [31:0]   stData,
    input  logic [3:0]    stOp,
    input  logic          ldReq,
    input  logic [31:0]   ldAddr,
    input  logic [3:0]    ldOp,
    input  logic          dmReady,
    output logic          stall,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count,
    output logic          dmWrite,
    output logic [31:0]   dmDst,
    output logic [31:0]   dmWd,
    output logic [3:0]    dmOp
);
    localparam int PW = $clog2(DEPTH);

    logic [31:0]      r_addr [DEPTH];
    logic [31:0]      r_data [DEPTH];
    logic [3:0]       r_op   [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [PW-1:0]    r_wptr, r_rptr;
    logic [CW-1:0]    r_count;

    logic w_hit, w_ldGo, w_pop, w_push, w_full, w_empty;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);

    // Word-granular match; partial-word overlap is treated as a hit on purpose.
    always_comb begin
        w_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            if (r_vld[i] && (r_addr[i][31:2] == ldAddr[31:2])) w_hit = 1'b1;
        w_hit = w_hit && ldReq;
    end

    assign w_ldGo = ldReq && dmReady && !w_hit && !reset;
    assign w_pop  = !w_ldGo && !w_empty && dmReady;
    assign w_push = stWrite && (!w_full || w_pop);

    always_comb begin
        dmWrite = 1'b0;
        dmDst   = '0;
        dmWd    = '0;
        dmOp    = '0;
        if (w_ldGo) begin
            dmDst = ldAddr;
            dmOp  = ldOp;
        end else if (w_pop) begin
            dmWrite = 1'b1;
            dmDst   = r_addr[r_rptr];
            dmWd    = r_data[r_rptr];
            dmOp    = r_op[r_rptr];
        end
    end

    // Reset is folded in so stall drops the instant reset is asserted.
    assign stall = !reset && ((ldReq && (w_hit || !dmReady)) || (stWrite && w_full && !w_pop));
    assign full  = w_full;
    assign empty = w_empty;
    assign count = r_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_wptr] <= stAddr;
            r_data[r_wptr] <= stData;
            r_op[r_wptr]   <= stOp;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_vld   <= '0;
        end else begin
            // Clear before set: when full, push and pop share one slot and it must stay valid.
            if (w_pop)  r_vld[r_rptr] <= 1'b0;
            if (w_push) r_vld[r_wptr] <= 1'b1;
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            if (w_push) r_wptr <= r_wptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: tb/tb_m_dm_sbuf.sv
// Scoreboarded bench for m_dm_sbuf: a queue model predicts port arbitration and flags;
// a negedge monitor checks every drained store against the expected FIFO order.
module tb_m_dm_sbuf;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          stWrite, ldReq, dmReady;
    logic [31:0]   stAddr, stData, ldAddr;
    logic [3:0]    stOp, ldOp;
    logic          stall, full, empty, dmWrite;
    logic [CW-1:0] count;
    logic [31:0]   dmDst, dmWd;
    logic [3:0]    dmOp;

    m_dm_sbuf #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk(clk), .reset(reset),
        .stWrite(stWrite), .stAddr(stAddr), .stData(stData), .stOp(stOp),
        .ldReq(ldReq), .ldAddr(ldAddr), .ldOp(ldOp), .dmReady(dmReady),
        .stall(stall), .full(full), .empty(empty), .count(count),
        .dmWrite(dmWrite), .dmDst(dmDst), .dmWd(dmWd), .dmOp(dmOp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  o;
    } st_t;

    st_t mq[$];     // model of buffer contents
    st_t exp_q[$];  // expected drain order for the monitor
    int  n_chk = 0;
    int  n_fail = 0;
    int  n_wr = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && dmWrite) begin
            st_t e;
            n_wr++;
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL drain_unexpected: got write to %h expected none at %0t", dmDst, $time);
            end else begin
                e = exp_q.pop_front();
                chk("drain_addr", dmDst, e.a);
                chk("drain_data", dmWd, e.d);
                chk("drain_op", {28'h0, dmOp}, {28'h0, e.o});
            end
        end
    end

    // One clock of stimulus, entered and left at posedge+1.
    task automatic cyc(input logic st, input logic [31:0] sa, input logic [31:0] sd, input logic [3:0] so,
                       input logic lr, input logic [31:0] la, input logic [3:0] lo, input logic rdy);
        bit hit, go, pop, push, stl;
        int n;
        st_t e;
        stWrite = st; stAddr = sa; stData = sd; stOp = so;
        ldReq = lr; ldAddr = la; ldOp = lo; dmReady = rdy;
        n = mq.size();
        hit = 1'b0;
        foreach (mq[i]) if (lr && (mq[i].a[31:2] == la[31:2])) hit = 1'b1;
        go   = lr && rdy && !hit;
        pop  = !go && (n > 0) && rdy;
        push = st && ((n < DEPTH) || pop);
        stl  = (lr && (hit || !rdy)) || (st && (n == DEPTH) && !pop);
        @(negedge clk);
        chk("stall", {31'h0, stall}, {31'h0, stl});
        chk("count", {29'h0, count}, n);
        chk("full", {31'h0, full}, {31'h0, n == DEPTH});
        chk("empty", {31'h0, empty}, {31'h0, n == 0});
        chk("dmWrite", {31'h0, dmWrite}, {31'h0, pop});
        if (go) begin
            chk("ld_dst", dmDst, la);
            chk("ld_wd", dmWd, 32'h0);
            chk("ld_op", {28'h0, dmOp}, {28'h0, lo});
        end else if (!pop) begin
            chk("idle_dst", dmDst, 32'h0);
            chk("idle_wd", dmWd, 32'h0);
            chk("idle_op", {28'h0, dmOp}, 32'h0);
        end
        @(posedge clk);
        if (pop) void'(mq.pop_front());
        if (push) begin
            e.a = sa; e.d = sd; e.o = so;
            mq.push_back(e);
            exp_q.push_back(e);
        end
        #1;
    endtask

    task automatic idle(input logic rdy);
        cyc(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 4'h0, rdy);
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [3:0] o, input logic rdy);
        cyc(1'b1, a, d, o, 1'b0, 32'h0, 4'h0, rdy);
    endtask

    task automatic ld(input logic [31:0] a, input logic [3:0] o, input logic rdy);
        cyc(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, a, o, rdy);
    endtask

    initial begin
        int w0;
        reset = 1'b1;
        stWrite = 0; stAddr = 0; stData = 0; stOp = 0;
        ldReq = 0; ldAddr = 0; ldOp = 0; dmReady = 1;
        #3;
        chk("rst_count", {29'h0, count}, 32'h0);
        chk("rst_empty", {31'h0, empty}, 32'h1);
        chk("rst_full", {31'h0, full}, 32'h0);
        chk("rst_stall", {31'h0, stall}, 32'h0);
        chk("rst_dmWrite", {31'h0, dmWrite}, 32'h0);
        chk("rst_dmDst", dmDst, 32'h0);
        @(posedge clk); #1 reset = 1'b0;

        // single store drains next cycle, then buffer is empty
        st(32'h10, 32'h12345678, 4'h1, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // fill, blocked fifth store, then pop+push at full
        for (int i = 0; i < 4; i++) st(32'h20 + 4*i, 32'hA000 + i, 4'h2, 1'b0);
        st(32'h40, 32'hBAD0, 4'h3, 1'b0);
        st(32'h44, 32'hB044, 4'h3, 1'b1);
        repeat (6) idle(1'b1);

        // load hitting pending word stalls until both matches pop
        st(32'h16, 32'h1600, 4'h1, 1'b0);
        st(32'h14, 32'h1400, 4'h2, 1'b0);
        repeat (3) ld(32'h14, 4'h5, 1'b1);

        // non-hitting load takes the port; store drains afterwards
        st(32'h10, 32'h1010, 4'h1, 1'b0);
        ld(32'h20, 4'h6, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // six stores with dmReady toggling, across pointer wrap
        w0 = n_wr;
        for (int i = 0; i < 6; i++) st(32'h4 * i, 32'hC000 + i, 4'h7, (i % 2) == 0);
        repeat (6) idle(1'b1);
        chk("six_pulses", n_wr - w0, 32'd6);

        // asynchronous reset with pending stores
        for (int i = 0; i < 3; i++) st(32'h80 + 4*i, 32'hD000 + i, 4'h1, 1'b0);
        stWrite = 1; ldReq = 1; ldAddr = 32'h80; dmReady = 0;
        #2 reset = 1'b1;
        #1;
        chk("arst_count", {29'h0, count}, 32'h0);
        chk("arst_empty", {31'h0, empty}, 32'h1);
        chk("arst_dmWrite", {31'h0, dmWrite}, 32'h0);
        chk("arst_stall", {31'h0, stall}, 32'h0);
        mq.delete();
        exp_q.delete();
        @(posedge clk); #1 reset = 1'b0;
        repeat (4) idle(1'b1);

        // randomized traffic over a small address window to provoke hits
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] a, d;
            logic [3:0]  o;
            int          k;
            a = {26'h0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            d = $urandom;
            o = 4'($urandom);
            k = $urandom_range(0, 9);
            if (k < 4)      st(a, d, o, $urandom_range(0, 9) < 7);
            else if (k < 7) ld(a, o, $urandom_range(0, 9) < 7);
            else            idle($urandom_range(0, 9) < 7);
        end
        repeat (8) idle(1'b1);
        chk("drain_complete", exp_q.size(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
